mp_add_sequencer: RTL and testbench

MP_ADD_SEQUENCER -- requirements
Module: mp_add_sequencer

---
 rtl/mp_add_sequencer_if.sv | 37 +++
 rtl/mp_add_sequencer.sv | 152 +++++++++++++++
 tb/tb_mp_add_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mp_add_sequencer_if.sv
// Operand/result streaming bundle for mp_add_sequencer.
// Defining MP_ADD_OVFL_EN adds the out_ovf signal.
interface mp_add_sequencer_if #(
  parameter int unsigned W = 64
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_sub;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_last;
  logic         out_cout;
  logic         err;
`ifdef MP_ADD_OVFL_EN
  logic         out_ovf;
`endif

  modport master (
    output in_valid, in_a, in_b, in_sub, in_last, out_ready,
`ifdef MP_ADD_OVFL_EN
    input  out_ovf,
`endif
    input  in_ready, out_valid, out_sum, out_last, out_cout, err
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, in_last, out_ready,
`ifdef MP_ADD_OVFL_EN
    output out_ovf,
`endif
    output in_ready, out_valid, out_sum, out_last, out_cout, err
  );
endinterface

// File: rtl/mp_add_sequencer.sv
// Word-serial multi-precision add/subtract around one shared W-bit Kogge-Stone adder.
// Defining MP_ADD_OVFL_EN adds a signed-overflow output for the final word.
module mp_add_sequencer #(
  parameter int unsigned W    = 64,
  parameter int unsigned MAXW = 8
) (
  input logic                clk,
  input logic                rst,
  mp_add_sequencer_if.slave  bus
);

  localparam int unsigned CW  = (MAXW > 1) ? $clog2(MAXW) : 1;
  localparam int unsigned LVL = (W > 1) ? $clog2(W) : 1;

  typedef enum logic {IDLE, ACC} state_e;

  state_e       state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic         carry_q, carry_d;
  logic         sub_q, sub_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_sum_q, out_sum_d;
  logic         out_last_q, out_last_d;
  logic         out_cout_q, out_cout_d;
  logic         err_q, err_d;

  logic         xfer, first, at_limit, final_w, sub_eff, add_cin;
  logic [W-1:0] add_a, add_b, add_sum, add_p, add_g0, add_c;
  logic         add_cout;

  assign bus.in_ready = !out_valid_q | bus.out_ready;
  assign xfer         = bus.in_valid & bus.in_ready;
  assign first        = (state_q == IDLE);
  assign at_limit     = (cnt_q == CW'(MAXW - 1));
  assign final_w      = bus.in_last | at_limit;

  assign sub_eff = first ? bus.in_sub : sub_q;
  assign add_cin = first ? bus.in_sub : carry_q;
  assign add_a   = bus.in_a;
  assign add_b   = bus.in_b ^ {W{sub_eff}};

  // Carry-in is folded into bit 0's generate so the prefix tree yields carries directly.
  assign add_p  = add_a ^ add_b;
  assign add_g0 = (add_a & add_b) | {{(W-1){1'b0}}, add_p[0] & add_cin};

  for (genvar l = 0; l < LVL; l++) begin : g_stage
    logic [W-1:0] gi, pi, go, po;
    if (l == 0) begin : g_src
      assign gi = add_g0;
      assign pi = add_p;
    end else begin : g_chain
      assign gi = g_stage[l-1].go;
      assign pi = g_stage[l-1].po;
    end
    for (genvar i = 0; i < W; i++) begin : g_bit
      if (i >= (1 << l)) begin : g_op
        assign go[i] = gi[i] | (pi[i] & gi[i - (1 << l)]);
        assign po[i] = pi[i] & pi[i - (1 << l)];
      end else begin : g_pass
        assign go[i] = gi[i];
        assign po[i] = pi[i];
      end
    end
  end

  logic unused_po;
  assign unused_po = &{1'b0, g_stage[LVL-1].po};

  assign add_c    = {g_stage[LVL-1].go[W-2:0], add_cin};
  assign add_sum  = add_p ^ add_c;
  assign add_cout = g_stage[LVL-1].go[W-1];

`ifdef MP_ADD_OVFL_EN
  logic out_ovf_q, out_ovf_d;
  assign bus.out_ovf = out_ovf_q;
`endif

  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_cout  = out_cout_q;
  assign bus.err       = err_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    sub_d       = sub_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_last_d  = out_last_q;
    out_cout_d  = out_cout_q;
    err_d       = err_q;
`ifdef MP_ADD_OVFL_EN
    out_ovf_d   = out_ovf_q;
`endif
    if (xfer) begin
      out_valid_d = 1'b1;
      out_sum_d   = add_sum;
      out_last_d  = final_w;
      out_cout_d  = final_w & add_cout;
`ifdef MP_ADD_OVFL_EN
      out_ovf_d   = final_w & (add_c[W-1] ^ add_cout);
`endif
      if (first) sub_d = bus.in_sub;
      // A new operation clears the sticky error unless its own first word overruns.
      err_d = ((!first) & err_q) | (at_limit & !bus.in_last);
      if (final_w) begin
        state_d = IDLE;
        cnt_d   = '0;
        carry_d = 1'b0;
      end else begin
        state_d = ACC;
        cnt_d   = cnt_q + 1'b1;
        carry_d = add_cout;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      sub_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_last_q  <= 1'b0;
      out_cout_q  <= 1'b0;
      err_q       <= 1'b0;
`ifdef MP_ADD_OVFL_EN
      out_ovf_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      sub_q       <= sub_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_last_q  <= out_last_d;
      out_cout_q  <= out_cout_d;
      err_q       <= err_d;
`ifdef MP_ADD_OVFL_EN
      out_ovf_q   <= out_ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Directed vector bench for mp_add_sequencer at W=8, MAXW=4.
// Checks out_ovf as well when MP_ADD_OVFL_EN is defined.
module tb_mp_add_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mp_add_sequencer_if #(.W(8)) bus ();

  mp_add_sequencer #(.W(8), .MAXW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic       last;
    logic [7:0] sum;
    logic       elast;
    logic       cout;
    logic       err;
    logic       ovf;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one word and hold it until accepted; returns #1 after the accepting edge.
  task automatic do_xfer(input logic [7:0] a, input logic [7:0] b,
                         input logic sub, input logic last);
    int n;
    @(negedge clk);
    bus.in_a = a; bus.in_b = b; bus.in_sub = sub; bus.in_last = last;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      failures++;
      $display("FAIL in_ready_timeout: got 0 expected 1 within 20 cycles");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{8'h01, 8'h00, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[7]  = '{8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[10] = '{8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[11] = '{8'h7F, 8'h01, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1};

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
    bus.in_sub = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_sum",   32'(bus.out_sum),   32'd0);
    chk("rst_out_last",  32'(bus.out_last),  32'd0);
    chk("rst_out_cout",  32'(bus.out_cout),  32'd0);
    chk("rst_err",       32'(bus.err),       32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Sub flag for words 4..6 is sampled only on word 4; vt[5].sub=0 must be ignored.
    for (int i = 0; i < 12; i++) begin
      do_xfer(vt[i].a, vt[i].b, vt[i].sub, vt[i].last);
      chk($sformatf("v%0d_valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("v%0d_sum",   i), 32'(bus.out_sum),   32'(vt[i].sum));
      chk($sformatf("v%0d_last",  i), 32'(bus.out_last),  32'(vt[i].elast));
      if (vt[i].elast)
        chk($sformatf("v%0d_cout", i), 32'(bus.out_cout), 32'(vt[i].cout));
      chk($sformatf("v%0d_err",   i), 32'(bus.err),       32'(vt[i].err));
`ifdef MP_ADD_OVFL_EN
      chk($sformatf("v%0d_ovf",   i), 32'(bus.out_ovf),   32'(vt[i].ovf));
`endif
    end

    @(posedge clk);
    #1;
    chk("drain_out_valid", 32'(bus.out_valid), 32'd0);

    // Backpressure: 3-word add 0x01FFFF + 0x000001, stalled after word 1.
    do_xfer(8'hFF, 8'h01, 1'b0, 1'b0);
    chk("bp_w1_sum", 32'(bus.out_sum), 32'h00);
    bus.out_ready = 1'b0;
    bus.in_a = 8'hFF; bus.in_b = 8'h00; bus.in_sub = 1'b0; bus.in_last = 1'b0;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("bp_stall%0d_in_ready", c),  32'(bus.in_ready),  32'd0);
      chk($sformatf("bp_stall%0d_out_valid", c), 32'(bus.out_valid), 32'd1);
      chk($sformatf("bp_stall%0d_out_sum", c),   32'(bus.out_sum),   32'h00);
      chk($sformatf("bp_stall%0d_out_last", c),  32'(bus.out_last),  32'd0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    do_xfer(8'hFF, 8'h00, 1'b0, 1'b0);
    chk("bp_w2_sum",  32'(bus.out_sum),  32'h00);
    chk("bp_w2_last", 32'(bus.out_last), 32'd0);
    do_xfer(8'h01, 8'h00, 1'b0, 1'b1);
    chk("bp_w3_sum",  32'(bus.out_sum),  32'h02);
    chk("bp_w3_last", 32'(bus.out_last), 32'd1);
    chk("bp_w3_cout", 32'(bus.out_cout), 32'd0);

    // Reset after word 1 leaves a pending carry; the next word must start fresh.
    do_xfer(8'hFF, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
    @(negedge clk);
    rst = 1'b0;
    do_xfer(8'h80, 8'h80, 1'b0, 1'b1);
    chk("post_rst_sum",  32'(bus.out_sum),  32'h00);
    chk("post_rst_last", 32'(bus.out_last), 32'd1);
    chk("post_rst_cout", 32'(bus.out_cout), 32'd1);
    chk("post_rst_err",  32'(bus.err),      32'd0);
`ifdef MP_ADD_OVFL_EN
    chk("post_rst_ovf",  32'(bus.out_ovf),  32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
